// File: rtl/max_sub_stage.sv
// max_sub_stage
// Front end of the pseudo-softmax datapath. Collects one vector of N signed
// logits while tracking their maximum, then replays every element in arrival
// order together with its shift amount (max - x) for the power-of-two stage.
//
// Ports
//   clk        clock, rising edge
//   rst        synchronous reset, active high
//   in_valid   upstream element valid
//   in_ready   stage accepts an element (high only while collecting)
//   in_data    signed logit
//   out_valid  output pair valid (registered)
//   out_ready  downstream accepts pair
//   out_data   original logit, replayed in arrival order
//   out_shift  unsigned shift amount = max - x
//   out_idx    element index 0..N-1
//   out_last   high with element N-1
module max_sub_stage #(
    parameter int DATA_W = 8,
    parameter int N      = 4,
    parameter int IDX_W  = $clog2(N)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [DATA_W-1:0] out_shift,
    output logic [IDX_W-1:0]  out_idx,
    output logic              out_last
);

    typedef enum logic {S_COLLECT, S_EMIT} state_t;

    localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

    state_t            r_state, w_state_nxt;
    logic [IDX_W-1:0]  r_count, w_count_nxt;
    logic [DATA_W-1:0] r_max, w_max_nxt;
    logic [DATA_W-1:0] r_buf [N];

    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_data;
    logic [DATA_W-1:0] r_out_shift;
    logic [IDX_W-1:0]  r_out_idx;
    logic              r_out_last;

    logic              w_in_acc;
    logic              w_out_acc;
    logic              w_load;      // present a new pair next cycle
    logic              w_drain;     // final pair accepted
    logic [IDX_W-1:0]  w_ld_idx;
    logic [DATA_W-1:0] w_ld_data;
    logic [DATA_W:0]   w_diff;
    logic              w_diff_unused;

    // Next-state / datapath control
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_max_nxt   = r_max;
        w_in_acc    = 1'b0;
        w_out_acc   = 1'b0;
        w_load      = 1'b0;
        w_drain     = 1'b0;
        w_ld_idx    = '0;
        case (r_state)
            S_COLLECT: begin
                w_in_acc = in_valid;
                if (w_in_acc) begin
                    // Element 0 seeds the max so nothing carries over between vectors
                    if (r_count == '0 || $signed(in_data) > $signed(r_max))
                        w_max_nxt = in_data;
                    if (r_count == LAST) begin
                        w_count_nxt = '0;
                        w_state_nxt = S_EMIT;
                        w_load      = 1'b1;   // element 0 is already buffered (N >= 2)
                    end else begin
                        w_count_nxt = r_count + IDX_W'(1);
                    end
                end
            end
            S_EMIT: begin
                w_out_acc = r_out_valid && out_ready;
                w_ld_idx  = r_out_idx + IDX_W'(1);
                if (w_out_acc) begin
                    if (r_out_idx == LAST) begin
                        w_drain     = 1'b1;
                        w_state_nxt = S_COLLECT;
                    end else begin
                        w_load = 1'b1;
                    end
                end
            end
            default: w_state_nxt = S_COLLECT;
        endcase
    end

    // Shift computed one bit wider; max >= x keeps the result within DATA_W unsigned bits
    assign w_ld_data     = r_buf[w_ld_idx];
    assign w_diff        = {w_max_nxt[DATA_W-1], w_max_nxt} - {w_ld_data[DATA_W-1], w_ld_data};
    assign w_diff_unused = w_diff[DATA_W];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_COLLECT;
            r_count     <= '0;
            r_max       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_shift <= '0;
            r_out_idx   <= '0;
            r_out_last  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_max   <= w_max_nxt;
            if (w_load) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_ld_data;
                r_out_shift <= w_diff[DATA_W-1:0];
                r_out_idx   <= w_ld_idx;
                r_out_last  <= (w_ld_idx == LAST);
            end else if (w_drain) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    // Vector storage needs no reset: every slot is written before it is read
    always_ff @(posedge clk) begin
        if (w_in_acc)
            r_buf[r_count] <= in_data;
    end

    assign in_ready  = (r_state == S_COLLECT);
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_shift = r_out_shift;
    assign out_idx   = r_out_idx;
    assign out_last  = r_out_last;

endmodule

// File: doc/max_sub_stage.md
Name: max_sub_stage

Overview:
Front-end stage of the pseudo-softmax datapath; sits directly upstream of the power-of-two shift stage. Collects one vector of N signed logits and tracks the running maximum. It then replays each element with its shift amount (max - x), which the shift stage uses to form 2^-(max-x). Valid/ready handshakes on both sides; the whole vector is buffered internally.

Parameters:
DATA_W, 8, logit width (two's complement signed)
N, 4, elements per vector (N >= 2)
IDX_W, $clog2(N), element index width

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
in_valid  input  1  upstream element valid
in_ready  output  1  stage accepts element this cycle
in_data  input  DATA_W  signed logit
out_valid  output  1  output pair valid
out_ready  input  1  downstream accepts pair this cycle
out_data  output  DATA_W  original logit, replayed in arrival order
out_shift  output  DATA_W  unsigned shift amount = max - x
out_idx  output  IDX_W  element index 0..N-1
out_last  output  1  high with element N-1

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high on rst.
- Reset values: state=COLLECT, count=0, max cleared, out_valid=0, out_data=0, out_shift=0, out_idx=0, out_last=0.
- in_ready is 1 in COLLECT and 0 in EMIT. It depends on state only, never on in_valid.
- COLLECT state:
  - On in_valid&&in_ready, write in_data to buf[count] and increment count.
  - On element 0, max := in_data. Otherwise max := (in_data > max, signed compare) ? in_data : max.
  - When the accept has count==N-1: count := 0 and state := EMIT.
- EMIT state:
  - Outputs are registered. out_valid rises on the clock edge that enters EMIT, so the first pair is valid exactly 1 cycle after the last input is accepted.
  - Each presented pair: out_data=buf[idx], out_shift=max-buf[idx], out_idx=idx, out_last=(idx==N-1).
  - Hold rule: while out_valid&&!out_ready, all out_* stay stable.
  - On out_valid&&out_ready with idx<N-1, the next pair is presented the following cycle. Full throughput is 1 pair/cycle.
  - On the accept of the pair with idx==N-1: out_valid := 0 and state := COLLECT. in_ready is 1 in the next cycle.
- Arithmetic:
  - Subtraction is done at DATA_W+1 bits signed, and the low DATA_W bits are taken as unsigned.
  - max >= x always holds, so the result lies in 0..2^DATA_W-1 with no overflow. Example: max=127, x=-128 gives 255.
- Ties: equal maxima are harmless; every element equal to max gets shift 0.
- Vector overlap: a new vector is never accepted during EMIT (no overlap). Upstream stalls.
- Reset mid-operation: the partial vector or partial emit is discarded. Behaviour returns to reset values on the next edge, with no spurious out_valid.
- Stalls: in_valid gaps during COLLECT stall without corrupting count or max. out_ready may toggle arbitrarily during EMIT.

Test Plan:
1. N=4, inputs 3,7,-2,7 back-to-back with out_ready=1 -> first out_valid 1 cycle after 4th accept. Pairs in order (3,4),(7,0),(-2,9),(7,0), idx 0..3, out_last only on idx 3, in_ready back to 1 the next cycle.
2. Extremes: inputs -128,127,0,-1 -> shifts 255,0,127,128. No wrap.
3. Backpressure: same vector as 1, out_ready low 3 cycles on pair idx 1 -> (7,0) held stable throughout. in_valid asserted meanwhile is ignored (in_ready=0). No element lost or duplicated.
4. Sparse input: in_valid high every 3rd cycle for 1,2,3,4 -> shifts 3,2,1,0. The max is unaffected by idle cycles.
5. Reset mid-emit: rst pulse after pair idx 1 accepted -> out_valid=0 and in_ready=1 next cycle. A following vector 5,5,5,5 yields all shifts 0 with idx restarting at 0.
6. Two consecutive vectors 0,1,2,3 then -4,-3,-2,-1 -> max 3 for the first, -1 for the second. Shifts 3,2,1,0 for both. There is no max carry-over between vectors.
